// File: rtl/strobe_seq_pkg.sv
// Shared types and widths for the strobe sequencer.
// Hold/stall support is enabled by defining STROBE_SEQ_WAIT_EN.
package strobe_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned DWELL_W = 2;

  function automatic logic [DWELL_W-1:0] dwell_limit(input int unsigned dwell);
    return DWELL_W'(dwell - 1);
  endfunction

endpackage

// File: rtl/strobe_dwell_ctr.sv
// Per-phase dwell counter: cleared by load, counts on enable,
// flags expired in the last cycle of a phase.
module strobe_dwell_ctr
  import strobe_seq_pkg::*;
#(
  parameter int unsigned DWELL = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam logic [DWELL_W-1:0] LIMIT = dwell_limit(DWELL);

  logic [DWELL_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/strobe_sequencer.sv
// Steps a 3-to-8 decoder select through first..LAST_PHASE, DWELL cycles each.
// Define STROBE_SEQ_WAIT_EN to add the hold (stall) input.
module strobe_sequencer
  import strobe_seq_pkg::*;
#(
  parameter int unsigned LAST_PHASE = 7,
  parameter int unsigned DWELL      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PHASE_W-1:0] first,
`ifdef STROBE_SEQ_WAIT_EN
  input  logic               hold,
`endif
  output logic [PHASE_W-1:0] sel,
  output logic               g2a_n,
  output logic               busy,
  output logic               done
);

  localparam logic [PHASE_W-1:0] LAST = LAST_PHASE[PHASE_W-1:0];

  state_t             state_q;
  state_t             state_n;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_n;
  logic               ctr_load;
  logic               ctr_en;
  logic               expired;
  logic               stall;

`ifdef STROBE_SEQ_WAIT_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  strobe_dwell_ctr #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk     (clk),
    .reset   (reset),
    .load    (ctr_load),
    .enable  (ctr_en),
    .expired (expired)
  );

  // Phases past LAST end the run instead of wrapping through 7->0.
  always_comb begin
    state_n  = state_q;
    phase_n  = phase_q;
    ctr_load = 1'b0;
    ctr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n  = RUN;
          phase_n  = first;
          ctr_load = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          if (expired) begin
            ctr_load = 1'b1;
            if (phase_q >= LAST) begin
              state_n = DONE;
            end else begin
              phase_n = phase_q + 1'b1;
            end
          end else begin
            ctr_en = 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // sel and the strobes share one register stage so they switch together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      g2a_n   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      g2a_n   <= (state_n != RUN);
      busy    <= (state_n != IDLE);
      done    <= (state_n == DONE);
    end
  end

  assign sel = phase_q;

endmodule
